asrv32_fetch_queue: RTL

//  Parametrised instruction prefetch unit for the next-generation asrv32 core.

---
 rtl/asrv32_fetch_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/asrv32_fetch_queue.sv
// Instruction prefetch queue: issues pipelined req/gnt/rvalid fetches and returns
// {pc, inst} in order over valid/ready. On redirect it flushes and squashes any
// responses still in flight.
module asrv32_fetch_queue #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   output logic                         o_imem_req,
   output logic [31:0]                  o_imem_addr,
   input  logic                         i_imem_gnt,
   input  logic                         i_imem_rvalid,
   input  logic [31:0]                  i_imem_rdata,
   input  logic                         i_redirect,
   input  logic [31:0]                  i_redirect_pc,
   output logic                         o_inst_valid,
   output logic [31:0]                  o_inst,
   output logic [31:0]                  o_inst_pc,
   input  logic                         i_inst_ready,
   output logic [$clog2(DEPTH+1)-1:0]   o_level,
   output logic                         o_proto_err
);

   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [LW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic          run_q, proto_err_q, proto_err_d;
   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic          grant, resp, drop, push, pop;
   logic [LW:0]   in_use;
   logic          unused_pc_bits;

   assign unused_pc_bits = ^i_redirect_pc[1:0];

   // Slots are reserved at grant time, so buffered plus in-flight never exceeds DEPTH.
   assign in_use       = {1'b0, count_q} + {1'b0, outst_q};
   assign o_imem_req   = run_q && (in_use < (LW+1)'(DEPTH));
   assign o_imem_addr  = fetch_pc_q;
   assign o_inst_valid = (count_q != '0) && !i_redirect;
   assign o_inst       = (count_q != '0) ? inst_mem[rd_ptr_q] : '0;
   assign o_inst_pc    = (count_q != '0) ? pc_mem[rd_ptr_q] : '0;
   assign o_level      = count_q;
   assign o_proto_err  = proto_err_q;

   always_comb begin
      grant       = o_imem_req && i_imem_gnt;
      resp        = i_imem_rvalid && (outst_q != '0);
      drop        = resp && (i_redirect || (discard_q != '0));
      push        = resp && !drop;
      pop         = o_inst_valid && i_inst_ready;
      outst_d     = outst_q + LW'(grant) - LW'(resp);
      proto_err_d = proto_err_q | (i_imem_rvalid && (outst_q == '0));

      count_d    = count_q + LW'(push) - LW'(pop);
      discard_d  = discard_q - LW'(resp && (discard_q != '0));
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
      resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;

      if (i_redirect) begin
         // Everything still in flight after this edge belongs to the old stream.
         count_d    = '0;
         discard_d  = outst_d;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
         resp_pc_d  = {i_redirect_pc[31:2], 2'b00};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_q       <= 1'b0;
         count_q     <= '0;
         outst_q     <= '0;
         discard_q   <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         fetch_pc_q  <= PC_RESET;
         resp_pc_q   <= PC_RESET;
         proto_err_q <= 1'b0;
      end else begin
         run_q       <= 1'b1;
         count_q     <= count_d;
         outst_q     <= outst_d;
         discard_q   <= discard_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         fetch_pc_q  <= fetch_pc_d;
         resp_pc_q   <= resp_pc_d;
         proto_err_q <= proto_err_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         inst_mem[wr_ptr_q] <= i_imem_rdata;
         pc_mem[wr_ptr_q]   <= resp_pc_q;
      end
   end

endmodule
